// File: rtl/ball_motion_engine.sv
// Frame-rate ball position engine: serve/pause/miss control, accelerating step,
// saturating arena clamps and a paddle-bounce counter. All outputs are registered.
module ball_motion_engine #(
    parameter int COORD_W         = 10,
    parameter int X_INIT          = 320,
    parameter int Y_INIT          = 240,
    parameter int X_MIN           = 8,
    parameter int X_MAX           = 631,
    parameter int Y_MIN           = 8,
    parameter int Y_MAX           = 471,
    parameter int STEP_W          = 3,
    parameter int STEP_INIT       = 2,
    parameter int STEP_MAX        = 6,
    parameter int SPEEDUP_BOUNCES = 8,
    parameter int HOLD_FRAMES     = 60,
    parameter int HOLD_W          = 6
) (
    input  logic               iFrame_CLK,
    input  logic               iRST,
    input  logic               iServe,
    input  logic [1:0]         iServe_dir,
    input  logic               iPause,
    input  logic [3:0]         iCrash,
    input  logic               iMiss,
    output logic [COORD_W-1:0] oBall_x,
    output logic [COORD_W-1:0] oBall_y,
    output logic [1:0]         oDir,
    output logic [STEP_W-1:0]  oStep,
    output logic [7:0]         oBounce_cnt,
    output logic               oMiss,
    output logic [1:0]         oState
);

    localparam int CW1 = COORD_W + 1;
    localparam logic [COORD_W-1:0] X_INIT_C  = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] Y_INIT_C  = COORD_W'(Y_INIT);
    localparam logic [COORD_W-1:0] X_MIN_C   = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MIN_C   = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] Y_MAX_C   = COORD_W'(Y_MAX);
    localparam logic [CW1-1:0]     X_MIN_W   = CW1'(X_MIN);
    localparam logic [CW1-1:0]     X_MAX_W   = CW1'(X_MAX);
    localparam logic [CW1-1:0]     Y_MIN_W   = CW1'(Y_MIN);
    localparam logic [CW1-1:0]     Y_MAX_W   = CW1'(Y_MAX);
    localparam logic [STEP_W-1:0]  STEP_INIT_C = STEP_W'(STEP_INIT);
    localparam logic [STEP_W-1:0]  STEP_MAX_C  = STEP_W'(STEP_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        PAUSE = 2'd2,
        MISS  = 2'd3
    } state_t;

    state_t              state_r, state_next;
    logic [COORD_W-1:0]  x_r, y_r, x_next, y_next;
    logic                x_dir_r, y_dir_r, x_dir_next, y_dir_next;
    logic [STEP_W-1:0]   step_r, step_next;
    logic [7:0]          cnt_r, cnt_next;
    logic                miss_r, miss_next;
    logic [HOLD_W-1:0]   hold_r, hold_next;

    logic                xd_new, yd_new, paddle_hit;
    logic [CW1-1:0]      step_ext, x_sum, y_sum;
    logic [COORD_W-1:0]  x_mv, y_mv;
    logic [7:0]          cnt_inc;
    logic [STEP_W-1:0]   step_inc;
    logic                speedup;

    // Reflection and saturating motion for one MOVE frame; reflection is applied
    // before the position step so the ball never travels into a wall it just hit.
    always_comb begin
        xd_new     = x_dir_r ? ~iCrash[3] : iCrash[2];
        yd_new     = y_dir_r ? ~iCrash[1] : iCrash[0];
        paddle_hit = ~y_dir_r & iCrash[0];
        step_ext   = CW1'(step_r);
        x_sum      = {1'b0, x_r} + step_ext;
        y_sum      = {1'b0, y_r} + step_ext;
        x_mv       = x_sum[COORD_W-1:0];
        y_mv       = y_sum[COORD_W-1:0];
        if (xd_new) begin
            x_mv = ({1'b0, x_r} < X_MIN_W + step_ext) ? X_MIN_C : x_r - COORD_W'(step_r);
        end else if (x_sum > X_MAX_W) begin
            x_mv = X_MAX_C;
        end
        if (yd_new) begin
            y_mv = ({1'b0, y_r} < Y_MIN_W + step_ext) ? Y_MIN_C : y_r - COORD_W'(step_r);
        end else if (y_sum > Y_MAX_W) begin
            y_mv = Y_MAX_C;
        end
        cnt_inc  = (cnt_r == 8'hFF) ? 8'hFF : cnt_r + 8'd1;
        step_inc = (step_r >= STEP_MAX_C) ? STEP_MAX_C : step_r + STEP_W'(1);
        speedup  = (cnt_r != 8'hFF) && ((32'(cnt_inc) % SPEEDUP_BOUNCES) == 0);
    end

    always_comb begin
        state_next = state_r;
        x_next     = x_r;
        y_next     = y_r;
        x_dir_next = x_dir_r;
        y_dir_next = y_dir_r;
        step_next  = step_r;
        cnt_next   = cnt_r;
        miss_next  = 1'b0;
        hold_next  = hold_r;
        case (state_r)
            IDLE: begin
                x_next = X_INIT_C;
                y_next = Y_INIT_C;
                if (iServe) begin
                    state_next = MOVE;
                    x_dir_next = iServe_dir[1];
                    y_dir_next = iServe_dir[0];
                    step_next  = STEP_INIT_C;
                    cnt_next   = 8'd0;
                end
            end
            MOVE: begin
                if (iMiss) begin
                    state_next = MISS;
                    miss_next  = 1'b1;
                    hold_next  = '0;
                end else if (iPause) begin
                    state_next = PAUSE;
                end else begin
                    x_dir_next = xd_new;
                    y_dir_next = yd_new;
                    x_next     = x_mv;
                    y_next     = y_mv;
                    if (paddle_hit) begin
                        cnt_next = cnt_inc;
                        if (speedup) begin
                            step_next = step_inc;
                        end
                    end
                end
            end
            PAUSE: begin
                if (!iPause) begin
                    state_next = MOVE;
                end
            end
            MISS: begin
                // The bounce count survives the return to IDLE so the score stays visible.
                if (hold_r == HOLD_LAST) begin
                    state_next = IDLE;
                    x_next     = X_INIT_C;
                    y_next     = Y_INIT_C;
                    step_next  = STEP_INIT_C;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_r + HOLD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iFrame_CLK or posedge iRST) begin
        if (iRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    always_ff @(posedge iFrame_CLK or posedge iRST) begin
        if (iRST) begin
            x_r     <= X_INIT_C;
            y_r     <= Y_INIT_C;
            x_dir_r <= 1'b0;
            y_dir_r <= 1'b0;
            step_r  <= STEP_INIT_C;
            cnt_r   <= 8'd0;
            miss_r  <= 1'b0;
            hold_r  <= '0;
        end else begin
            x_r     <= x_next;
            y_r     <= y_next;
            x_dir_r <= x_dir_next;
            y_dir_r <= y_dir_next;
            step_r  <= step_next;
            cnt_r   <= cnt_next;
            miss_r  <= miss_next;
            hold_r  <= hold_next;
        end
    end

    assign oBall_x     = x_r;
    assign oBall_y     = y_r;
    assign oDir        = {x_dir_r, y_dir_r};
    assign oStep       = step_r;
    assign oBounce_cnt = cnt_r;
    assign oMiss       = miss_r;
    assign oState      = state_r;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Scoreboard bench for ball_motion_engine: directed frames push hand-computed
// expectations; a negedge monitor pops and compares them against the outputs.
module tb_ball_motion_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serve = 1'b0;
    logic [1:0] serve_dir = 2'b00;
    logic       pause = 1'b0;
    logic [3:0] crash = 4'b0000;
    logic       miss_in = 1'b0;
    logic [9:0] ball_x, ball_y;
    logic [1:0] dir;
    logic [2:0] step;
    logic [7:0] bounce_cnt;
    logic       miss_out;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
        logic [2:0] step;
        logic [7:0] cnt;
        logic       miss;
        logic [1:0] state;
    } exp_t;

    exp_t exp_q[$];

    ball_motion_engine dut (
        .iFrame_CLK  (clk),
        .iRST        (rst),
        .iServe      (serve),
        .iServe_dir  (serve_dir),
        .iPause      (pause),
        .iCrash      (crash),
        .iMiss       (miss_in),
        .oBall_x     (ball_x),
        .oBall_y     (ball_y),
        .oDir        (dir),
        .oStep       (step),
        .oBounce_cnt (bounce_cnt),
        .oMiss       (miss_out),
        .oState      (state)
    );

    always #5 clk = ~clk;

    // One frame: drive inputs, take the edge, return to quiet inputs just after it.
    task automatic applyStimulus(input logic s, input logic [1:0] sd, input logic p,
                                 input logic [3:0] c, input logic m);
        serve     = s;
        serve_dir = sd;
        pause     = p;
        crash     = c;
        miss_in   = m;
        @(posedge clk);
        #1;
        serve     = 1'b0;
        serve_dir = 2'b00;
        pause     = 1'b0;
        crash     = 4'b0000;
        miss_in   = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic bounce_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, 4'b0001, 1'b0);
            applyStimulus(1'b0, 2'b00, 1'b0, 4'b0010, 1'b0);
        end
    endtask

    task automatic checkOutput(input string name, input int x, input int y, input logic [1:0] d,
                               input int st, input int cnt, input logic m, input logic [1:0] s);
        exp_t e;
        e.name  = name;
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.dir   = d;
        e.step  = 3'(st);
        e.cnt   = 8'(cnt);
        e.miss  = m;
        e.state = s;
        exp_q.push_back(e);
    endtask

    // Monitor: compares one queued expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ball_x !== e.x || ball_y !== e.y || dir !== e.dir || step !== e.step ||
                    bounce_cnt !== e.cnt || miss_out !== e.miss || state !== e.state) begin
                    errors++;
                    $display("[TB] FAIL %s: got x=%0d y=%0d dir=%b step=%0d cnt=%0d miss=%b state=%0d, expected x=%0d y=%0d dir=%b step=%0d cnt=%0d miss=%b state=%0d",
                             e.name, ball_x, ball_y, dir, step, bounce_cnt, miss_out, state,
                             e.x, e.y, e.dir, e.step, e.cnt, e.miss, e.state);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 320, 240, 2'b00, 2, 0, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 2'b00, 1'b0, 4'b0000, 1'b0);
        checkOutput("serve_edge", 320, 240, 2'b00, 2, 0, 1'b0, 2'd1);
        run_frames(3);
        checkOutput("three_frames", 326, 246, 2'b00, 2, 0, 1'b0, 2'd1);
        run_frames(37);
        checkOutput("travel_to_400", 400, 320, 2'b00, 2, 0, 1'b0, 2'd1);

        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0100, 1'b0);
        checkOutput("right_flip", 398, 322, 2'b10, 2, 0, 1'b0, 2'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0100, 1'b0);
        checkOutput("right_ignored", 396, 324, 2'b10, 2, 0, 1'b0, 2'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b1000, 1'b0);
        checkOutput("left_flip", 398, 326, 2'b00, 2, 0, 1'b0, 2'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b1000, 1'b0);
        checkOutput("left_ignored", 400, 328, 2'b00, 2, 0, 1'b0, 2'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b1100, 1'b0);
        checkOutput("both_flip_once", 398, 330, 2'b10, 2, 0, 1'b0, 2'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b1100, 1'b0);
        checkOutput("both_flip_back", 400, 332, 2'b00, 2, 0, 1'b0, 2'd1);

        bounce_pairs(7);
        checkOutput("seven_bounces", 428, 332, 2'b00, 2, 7, 1'b0, 2'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0001, 1'b0);
        checkOutput("eighth_bounce", 430, 330, 2'b01, 3, 8, 1'b0, 2'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0010, 1'b0);
        checkOutput("step3_applied", 433, 333, 2'b00, 3, 8, 1'b0, 2'd1);
        bounce_pairs(8);
        checkOutput("sixteen_bounces", 482, 334, 2'b00, 4, 16, 1'b0, 2'd1);
        bounce_pairs(24);
        checkOutput("step_cap", 631, 336, 2'b00, 6, 40, 1'b0, 2'd1);

        applyStimulus(1'b0, 2'b00, 1'b1, 4'b0100, 1'b1);
        checkOutput("miss_entry", 631, 336, 2'b00, 6, 40, 1'b1, 2'd3);
        applyStimulus(1'b1, 2'b11, 1'b0, 4'b0000, 1'b0);
        checkOutput("miss_pulse_end", 631, 336, 2'b00, 6, 40, 1'b0, 2'd3);
        run_frames(58);
        checkOutput("miss_hold_last", 631, 336, 2'b00, 6, 40, 1'b0, 2'd3);
        run_frames(1);
        checkOutput("miss_to_idle", 320, 240, 2'b00, 2, 40, 1'b0, 2'd0);

        applyStimulus(1'b1, 2'b00, 1'b0, 4'b0000, 1'b0);
        checkOutput("serve_again", 320, 240, 2'b00, 2, 0, 1'b0, 2'd1);
        run_frames(1);
        checkOutput("move_after_serve", 322, 242, 2'b00, 2, 0, 1'b0, 2'd1);
        applyStimulus(1'b0, 2'b00, 1'b1, 4'b0100, 1'b0);
        checkOutput("pause_entry", 322, 242, 2'b00, 2, 0, 1'b0, 2'd2);
        applyStimulus(1'b0, 2'b00, 1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 4'b0001, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b1, 4'b1111, 1'b0);
        checkOutput("pause_held", 322, 242, 2'b00, 2, 0, 1'b0, 2'd2);
        run_frames(1);
        checkOutput("resume_edge", 322, 242, 2'b00, 2, 0, 1'b0, 2'd1);
        run_frames(1);
        checkOutput("resume_move", 324, 244, 2'b00, 2, 0, 1'b0, 2'd1);

        run_frames(153);
        checkOutput("x_630", 630, 471, 2'b00, 2, 0, 1'b0, 2'd1);
        run_frames(1);
        checkOutput("clamp_x_max", 631, 471, 2'b00, 2, 0, 1'b0, 2'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0100, 1'b0);
        checkOutput("turn_left", 629, 471, 2'b10, 2, 0, 1'b0, 2'd1);
        run_frames(310);
        checkOutput("x_9", 9, 471, 2'b10, 2, 0, 1'b0, 2'd1);
        run_frames(1);
        checkOutput("clamp_x_min", 8, 471, 2'b10, 2, 0, 1'b0, 2'd1);
        run_frames(1);
        checkOutput("hold_x_min", 8, 471, 2'b10, 2, 0, 1'b0, 2'd1);

        applyStimulus(1'b0, 2'b00, 1'b0, 4'b0000, 1'b1);
        checkOutput("miss_again", 8, 471, 2'b10, 2, 0, 1'b1, 2'd3);
        run_frames(3);
        rst = 1'b1;
        checkOutput("async_reset", 320, 240, 2'b00, 2, 0, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", 320, 240, 2'b00, 2, 0, 1'b0, 2'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
